song_select_ctrl: RTL and testbench

SONG_SELECT_CTRL -- requirements
Module: song_select_ctrl

---
 rtl/song_select_ctrl.sv | 149 ++++++++++++++
 tb/tb_song_select_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/song_select_ctrl.sv
// Song-selection UI controller: debounces four push buttons and walks MENU/SELECT/PLAY,
// producing the selected song number and one-cycle play start/stop requests.
module song_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int SONG_MAX        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       btn_back,
  input  logic       song_done,
  output logic [3:0] num,
  output logic [2:0] mode,
  output logic       play_start,
  output logic       play_stop
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] NUM_MAX = 4'(SONG_MAX);

  localparam logic [2:0] MENU   = 3'b001;
  localparam logic [2:0] SELECT = 3'b010;
  localparam logic [2:0] PLAY   = 3'b100;

  localparam int UP   = 0;
  localparam int DOWN = 1;
  localparam int OK   = 2;
  localparam int BACK = 3;

  logic [3:0]       raw;
  logic [3:0]       sync_p0, sync_p1;
  logic [3:0]       lvl_p2, lvl_p3;
  logic [3:0]       press_p3;
  logic [CNT_W-1:0] cnt_p2 [4];
  logic [3:0]       ev;
  logic [2:0]       mode_nx;
  logic [3:0]       num_nx;
  logic             start_nx, stop_nx;

  assign raw = {btn_back, btn_ok, btn_down, btn_up};

  // Stage 0/1: two-flop synchronizers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_p2 <= '0;
      for (int i = 0; i < 4; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == lvl_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          lvl_p2[i] <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stage 3: rising-edge press pulses; releases are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_p3   <= '0;
      press_p3 <= '0;
    end else begin
      lvl_p3   <= lvl_p2;
      press_p3 <= lvl_p2 & ~lvl_p3;
    end
  end

  // Only the highest-priority press survives; the rest are dropped, not queued
  always_comb begin
    ev = '0;
    if (press_p3[BACK])      ev[BACK] = 1'b1;
    else if (press_p3[OK])   ev[OK]   = 1'b1;
    else if (press_p3[UP])   ev[UP]   = 1'b1;
    else if (press_p3[DOWN]) ev[DOWN] = 1'b1;
  end

  always_comb begin
    mode_nx  = mode;
    num_nx   = num;
    start_nx = 1'b0;
    stop_nx  = 1'b0;
    case (mode)
      MENU: begin
        if (ev[OK]) begin
          mode_nx = SELECT;
          num_nx  = 4'd1;
        end
      end
      SELECT: begin
        if (ev[BACK]) begin
          mode_nx = MENU;
        end else if (ev[OK]) begin
          mode_nx  = PLAY;
          start_nx = 1'b1;
        end else if (ev[UP]) begin
          num_nx = (num >= NUM_MAX) ? 4'd1 : num + 4'd1;
        end else if (ev[DOWN]) begin
          num_nx = (num <= 4'd1) ? NUM_MAX : num - 4'd1;
        end
      end
      PLAY: begin
        if (ev[BACK]) begin
          mode_nx = SELECT;
          stop_nx = 1'b1;
        end else if (song_done) begin
          mode_nx = SELECT;
        end
      end
      default: begin
        mode_nx = MENU;
        num_nx  = 4'd1;
      end
    endcase
  end

  // Stage 4: registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode       <= MENU;
      num        <= 4'd1;
      play_start <= 1'b0;
      play_stop  <= 1'b0;
    end else begin
      mode       <= mode_nx;
      num        <= num_nx;
      play_start <= start_nx;
      play_stop  <= stop_nx;
    end
  end

endmodule

// File: tb/tb_song_select_ctrl.sv
// Scoreboard bench for song_select_ctrl: stimulus queues expected output changes,
// a negedge monitor pops one entry per observed output change and compares.
module tb_song_select_ctrl;

  localparam logic [3:0] B_UP   = 4'b0001;
  localparam logic [3:0] B_DOWN = 4'b0010;
  localparam logic [3:0] B_OK   = 4'b0100;
  localparam logic [3:0] B_BACK = 4'b1000;

  localparam logic [2:0] MENU   = 3'b001;
  localparam logic [2:0] SELECT = 3'b010;
  localparam logic [2:0] PLAY   = 3'b100;

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, btn_ok, btn_back, song_done;
  logic [3:0] num;
  logic [2:0] mode;
  logic       play_start, play_stop;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] num;
    logic       st;
    logic       sp;
    int         cyc;
    string      name;
  } exp_t;

  exp_t        q[$];
  exp_t        e_m;
  logic [10:0] prev_m = '1;
  logic [10:0] cur_m;

  song_select_ctrl #(.DEBOUNCE_CYCLES(4), .SONG_MAX(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_ok     (btn_ok),
    .btn_back   (btn_back),
    .song_done  (song_done),
    .num        (num),
    .mode       (mode),
    .play_start (play_start),
    .play_stop  (play_stop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output bundle consumes one expectation
  always @(negedge clk) begin
    cur_m = {mode, num, play_start, play_stop};
    if (cur_m !== prev_m) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got mode=%b num=%0d start=%b stop=%b, required no change",
                 cyc, mode, num, play_start, play_stop);
      end else begin
        e_m = q.pop_front();
        if (cur_m !== {e_m.mode, e_m.num, e_m.st, e_m.sp}) begin
          fails++;
          $display("FAIL %s got mode=%b num=%0d start=%b stop=%b, required mode=%b num=%0d start=%b stop=%b",
                   e_m.name, mode, num, play_start, play_stop, e_m.mode, e_m.num, e_m.st, e_m.sp);
        end
        if (e_m.cyc >= 0) begin
          tests++;
          if (cyc != e_m.cyc) begin
            fails++;
            $display("FAIL %s_timing got cycle %0d, required cycle %0d", e_m.name, cyc, e_m.cyc);
          end
        end
      end
      prev_m = cur_m;
    end
  end

  task automatic expect_out(input logic [2:0] m, input logic [3:0] n, input logic st,
                            input logic sp, input int c, input string nm);
    exp_t e;
    e.mode = m; e.num = n; e.st = st; e.sp = sp; e.cyc = c; e.name = nm;
    q.push_back(e);
  endtask

  task automatic set_btn(input logic [3:0] mask);
    {btn_back, btn_ok, btn_down, btn_up} = mask;
  endtask

  // Hold buttons for 'hold' cycles; song_done pulses on loop index done_at (-1 = never)
  task automatic press(input logic [3:0] mask, input int hold, input int done_at);
    set_btn(mask);
    for (int i = 0; i < hold; i++) begin
      song_done = (i == done_at);
      @(negedge clk);
    end
    song_done = 1'b0;
    set_btn(4'b0000);
    repeat (12) @(negedge clk);
  endtask

  // With the driving negedge at cycle c, the first sampling edge is c+1 (edge 1) and the
  // debounced press is acted on so that outputs change at edge 8, i.e. cycle c+8.
  task automatic step(input logic [3:0] mask, input int hold, input int done_at,
                      input logic [2:0] m, input logic [3:0] n, input logic st,
                      input logic sp, input string nm);
    expect_out(m, n, st, sp, cyc + 8, nm);
    if (st || sp) expect_out(m, n, 1'b0, 1'b0, cyc + 9, {nm, "_end"});
    press(mask, hold, done_at);
  endtask

  initial begin
    reset = 1'b1;
    song_done = 1'b0;
    set_btn(4'b0000);
    expect_out(MENU, 4'd1, 1'b0, 1'b0, -1, "reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 3-cycle glitch must be rejected
    btn_ok = 1'b1;
    repeat (3) @(negedge clk);
    btn_ok = 1'b0;
    repeat (12) @(negedge clk);

    step(B_OK,   10, -1, SELECT, 4'd1, 1'b0, 1'b0, "menu_ok");
    step(B_UP,    6, -1, SELECT, 4'd2, 1'b0, 1'b0, "up_1");
    step(B_UP,    6, -1, SELECT, 4'd3, 1'b0, 1'b0, "up_2");
    step(B_UP,    6, -1, SELECT, 4'd1, 1'b0, 1'b0, "up_wrap");
    step(B_DOWN,  6, -1, SELECT, 4'd3, 1'b0, 1'b0, "down_wrap");
    step(B_DOWN,  6, -1, SELECT, 4'd2, 1'b0, 1'b0, "down_1");
    step(B_OK,    6, -1, PLAY,   4'd2, 1'b1, 1'b0, "play_start");
    step(B_BACK,  6, -1, SELECT, 4'd2, 1'b0, 1'b1, "play_stop");
    step(B_UP | B_DOWN, 6, -1, SELECT, 4'd3, 1'b0, 1'b0, "up_down_prio");
    step(B_OK,    6, -1, PLAY,   4'd3, 1'b1, 1'b0, "play_start2");
    step(B_BACK, 10,  7, SELECT, 4'd3, 1'b0, 1'b1, "back_done_coincide");
    step(B_OK,    6, -1, PLAY,   4'd3, 1'b1, 1'b0, "play_start3");

    // song_done alone ends playback without play_stop
    expect_out(SELECT, 4'd3, 1'b0, 1'b0, cyc + 1, "song_done_end");
    song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
    repeat (5) @(negedge clk);
    // song_done in SELECT is ignored
    song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
    repeat (5) @(negedge clk);

    step(B_OK,    6, -1, PLAY,   4'd3, 1'b1, 1'b0, "play_start4");

    // asynchronous reset between edges while playing
    @(posedge clk);
    #2;
    expect_out(MENU, 4'd1, 1'b0, 1'b0, cyc, "async_reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // MENU ignores song_done and up
    song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
    press(B_UP, 6, -1);

    // button already held when reset releases registers exactly one press
    reset = 1'b1;
    btn_ok = 1'b1;
    repeat (3) @(negedge clk);
    expect_out(SELECT, 4'd1, 1'b0, 1'b0, cyc + 8, "held_through_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    btn_ok = 1'b0;
    repeat (12) @(negedge clk);

    step(B_DOWN,  6, -1, SELECT, 4'd3, 1'b0, 1'b0, "down_wrap2");
    step(B_BACK,  6, -1, MENU,   4'd3, 1'b0, 1'b0, "back_menu");
    step(B_OK,    6, -1, SELECT, 4'd1, 1'b0, 1'b0, "menu_ok2");
    step(B_UP,   30, -1, SELECT, 4'd2, 1'b0, 1'b0, "held_no_repeat");
    repeat (20) @(negedge clk);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations got %0d unconsumed, required 0 (next: %s)",
               q.size(), q[0].name);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
